// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus: NREQ requesters offering (register, data) pairs to
// the write arbiter, which answers with a one-hot ready.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered
// write stage and a per-register pending-write scoreboard for issue stalls.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  regfile_write_arbiter_if.slave      rq,
  input  logic                        claim_valid,
  input  logic [AW-1:0]               claim_reg,
  output logic                        claim_ready,
  output logic                        RegWrite,
  output logic [AW-1:0]               WriteReg,
  output logic [DW-1:0]               WriteData,
  output logic [(1<<AW)-1:0]          busy
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   write_reg_q, write_reg_d;
  logic [DW-1:0]   write_data_q, write_data_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            xfer;
  logic [AW-1:0]   sel_reg;
  logic [DW-1:0]   sel_data;

  // Search starts one past the last winner and wraps, so the last winner
  // is considered last.
  always_comb begin
    int t;
    grant = '0;
    gidx  = ptr_q;
    xfer  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      t = int'(ptr_q) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!xfer && rq.req_valid[PW'(t)]) begin
        xfer  = 1'b1;
        gidx  = PW'(t);
      end
    end
    if (xfer) grant[gidx] = 1'b1;
  end

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == PW'(i)) begin
        sel_reg  = rq.req_reg[i*AW +: AW];
        sel_data = rq.req_data[i*DW +: DW];
      end
    end
  end

  assign rq.req_ready = grant;
  assign claim_ready  = claim_valid & ~busy_q[claim_reg];

  always_comb begin
    ptr_d        = ptr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (xfer) begin
      ptr_d        = gidx;
      reg_write_d  = (sel_reg != '0);
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
    end
  end

  // Clear is applied after set so a same-cycle set and clear of one register
  // leaves it idle.
  always_comb begin
    busy_d = busy_q;
    if (claim_ready) busy_d[claim_reg] = 1'b1;
    if (reg_write_q) busy_d[write_reg_q] = 1'b0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= PW'(NREQ - 1);
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign busy      = busy_q;

endmodule
